uart_receiver_baudrate: RTL and testbench
=========================================

// Module: uart_receiver_baudrate
// PURPOSE
//  Serial receive end of the team's UART link; mates with Transmitter_BaudRate (same BC baud table, 8E1 frame).
//  Oversamples Rxi with a per-bit counter, re-times to bit centres, deserialises 8 data bits LSB-first,
//  checks even parity and the stop bit, and presents one parallel byte per frame to the host logic.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock; baud table below is fixed for this value
//  CNT_W      9           baud counter width (must hold 434)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  synchronous, active-low reset
//  BC          in   3  baud select: 001->217, 010->109, 011->72, 100->36, others->434 clk/bit
//  Rxi         in   1  asynchronous serial line, idle high
//  Rx_data     out  8  last received byte
//  Rx_valid    out  1  one-cycle pulse, frame complete (set even when errors flagged)
//  Parity_err  out  1  parity of last frame wrong; valid with/after Rx_valid
//  Frame_err   out  1  stop bit of last frame sampled low
//  Rx_busy     out  1  high from start detection until return to IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE, counters 0, sync FFs 1, Rx_data=0, Rx_valid=0,
//   Parity_err=0, Frame_err=0, Rx_busy=0. Reset mid-frame aborts the frame; no Rx_valid.
//  Rxi passes a 2-FF synchroniser (reset value 1); FSM uses synced value rs, edge = rs_prev & ~rs.
//  M = Max_Cntr(BC), H = M>>1. BC latched into M at start detection; BC changes mid-frame ignored.
//  States: IDLE, START, DATA, PARITY, STOP, BREAK.
//   IDLE  : on edge -> START, cnt=0, Rx_busy=1.
//   START : cnt++; at cnt==H-1 sample rs: 1 -> IDLE (glitch, no flags touched), 0 -> DATA, cnt=0, bit=0.
//   DATA  : cnt++; at cnt==M-1 shift rs into sr[7] (LSB-first, right shift), cnt=0, bit++; after bit 7 -> PARITY.
//   PARITY: at cnt==M-1 capture p=rs, cnt=0 -> STOP.
//   STOP  : at cnt==M-1 sample rs; next edge: Rx_data=sr, Parity_err=(^sr)^p, Frame_err=~rs, Rx_valid=1;
//           rs=1 -> IDLE (re-armed at stop-bit centre, allows back-to-back frames);
//           rs=0 -> BREAK.
//   BREAK : wait for rs==1, then IDLE (no new start accepted while line held low).
//  Even parity: p must equal XOR of 8 data bits (00001011 -> p=1; 00001111 -> p=0).
//  Rx_data/Parity_err/Frame_err hold until the next frame completes; Rx_valid high exactly 1 cycle.
//  Latency: Rx_valid rises H+10*M+3 clk (+/-1) after Rxi falling edge of start bit.
//  Counter compares are equality on CNT_W bits; cnt never exceeds M-1 (no wrap case).
// STRUCTURE
//  Shared package uart_pkg: BC encodings, localparams 434/217/109/72/36, function max_cntr(BC),
//   state encoding localparams, frame constants (DATA_BITS=8, even parity). Transmitter to use same.
//  One sub-module: uart_rx_sync (2-FF synchroniser + falling-edge detect, rst_n -> 1).
//  Top holds FSM, baud counter, bit index, shift register, output regs.
// TESTING
//  1 BC=000, send 0x0B, p=1, stop=1 -> Rx_valid once ~H+10*434+3 clk later, Rx_data=0x0B, both errs 0.
//  2 BC=011 (72), send 0xE8 p=0 then 0x6F p=0 back-to-back -> two pulses, 0xE8 then 0x6F, no errors.
//  3 BC=001, send 0x0F with p=1 -> Rx_data=0x0F, Parity_err=1, Frame_err=0; next good frame clears it.
//  4 BC=100 (36), stop bit 0 then line low 500 clk -> Frame_err=1, one pulse, Rx_busy=1 until line high.
//  5 Rxi low pulse of H-4 clk -> no Rx_valid, Rx_busy drops, outputs unchanged; BC switch mid-frame ignored.
//  6 rst_n=0 for 1 clk during DATA bit 4 -> all outputs reset, no pulse; next full frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, BC encodings, frame constants and receiver states.
// The transmitter uses the same table so both ends agree on bit timing.
package uart_pkg;

  localparam int MAX_CNT_W = 9;

  localparam logic [MAX_CNT_W-1:0] BAUD_434 = 9'd434;
  localparam logic [MAX_CNT_W-1:0] BAUD_217 = 9'd217;
  localparam logic [MAX_CNT_W-1:0] BAUD_109 = 9'd109;
  localparam logic [MAX_CNT_W-1:0] BAUD_72  = 9'd72;
  localparam logic [MAX_CNT_W-1:0] BAUD_36  = 9'd36;

  localparam logic [2:0] BC_217 = 3'b001;
  localparam logic [2:0] BC_109 = 3'b010;
  localparam logic [2:0] BC_72  = 3'b011;
  localparam logic [2:0] BC_36  = 3'b100;

  localparam int   DATA_BITS  = 8;
  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Clocks per bit for a given baud select; unlisted codes fall back to the slowest rate.
  function automatic logic [MAX_CNT_W-1:0] max_cntr(input logic [2:0] bc);
    logic [MAX_CNT_W-1:0] m;
    case (bc)
      BC_217:  m = BAUD_217;
      BC_109:  m = BAUD_109;
      BC_72:   m = BAUD_72;
      BC_36:   m = BAUD_36;
      default: m = BAUD_434;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
// All flops reset to 1 so a line held idle never produces a spurious edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxi,
  output logic rs,
  output logic fall
);

  logic meta;
  logic rs_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      meta    <= rxi;
      rs      <= meta;
      rs_prev <= rs;
    end
  end

  assign fall = rs_prev & ~rs;

endmodule

// File: rtl/uart_receiver_baudrate.sv
// 8E1 UART receiver: bit-centre sampling from a per-bit counter, LSB-first deserialiser,
// even-parity and stop-bit checks, and a single-cycle valid pulse per completed frame.
module uart_receiver_baudrate
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] BC,
  input  logic       Rxi,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  output logic       Parity_err,
  output logic       Frame_err,
  output logic       Rx_busy
);

  // The baud table only holds for a 50 MHz clock and needs room for 434.
  if (CLK_HZ != 50_000_000 || CNT_W < MAX_CNT_W) begin : g_param_check
    $error("uart_receiver_baudrate: unsupported CLK_HZ/CNT_W");
  end

  logic             rs;
  logic             fall;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] m;
  logic [CNT_W-1:0] half_last;
  logic [CNT_W-1:0] bit_last;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic             par;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxi   (Rxi),
    .rs    (rs),
    .fall  (fall)
  );

  assign half_last = (m >> 1) - CNT_W'(1);
  assign bit_last  = m - CNT_W'(1);

  // START waits half a bit to land on the start-bit centre; every later stage waits a
  // full bit so samples stay centred. STOP returns to IDLE at the stop centre, which
  // leaves enough margin to catch a back-to-back start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      m          <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      par        <= 1'b0;
      Rx_data    <= '0;
      Rx_valid   <= 1'b0;
      Parity_err <= 1'b0;
      Frame_err  <= 1'b0;
      Rx_busy    <= 1'b0;
    end else begin
      Rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            cnt     <= '0;
            m       <= CNT_W'(max_cntr(BC));
            Rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == half_last) begin
            cnt <= '0;
            if (rs) begin
              state   <= ST_IDLE;
              Rx_busy <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == bit_last) begin
            cnt     <= '0;
            sr      <= {rs, sr[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_PARITY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == bit_last) begin
            cnt   <= '0;
            par   <= rs;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == bit_last) begin
            cnt        <= '0;
            Rx_data    <= sr;
            Parity_err <= ((^sr) ^ PARITY_ODD) != par;
            Frame_err  <= ~rs;
            Rx_valid   <= 1'b1;
            if (rs) begin
              state   <= ST_IDLE;
              Rx_busy <= 1'b0;
            end else begin
              state <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (rs) begin
            state   <= ST_IDLE;
            Rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          Rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver_baudrate.sv
// Directed bench for uart_receiver_baudrate: framed bytes at several baud rates, parity and
// stop errors, a start glitch, a mid-frame baud change and a mid-frame reset.
module tb_uart_receiver_baudrate;

  logic       clk;
  logic       rst_n;
  logic [2:0] BC;
  logic       Rxi;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Parity_err;
  logic       Frame_err;
  logic       Rx_busy;

  int test_count;
  int fail_count;
  int cyc;
  int pulse_count;
  int pulse_cyc;
  int frame_start;
  int exp_pulses;

  uart_receiver_baudrate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .Rxi        (Rxi),
    .Rx_data    (Rx_data),
    .Rx_valid   (Rx_valid),
    .Parity_err (Parity_err),
    .Frame_err  (Frame_err),
    .Rx_busy    (Rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts every cycle Rx_valid is high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (Rx_valid) begin
      pulse_count = pulse_count + 1;
      pulse_cyc   = cyc;
    end
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkLatency(input string tag, input int m);
    int lat;
    int want;
    lat  = pulse_cyc - frame_start;
    want = (m >> 1) + 10 * m + 3;
    test_count++;
    assert (lat >= want - 1 && lat <= want + 1)
    else begin
      fail_count++;
      $error("FAIL %s: observed latency %0d expected %0d +/-1", tag, lat, want);
    end
  endtask

  // Drives one full frame; leaves Rxi at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic stop, input int m);
    frame_start = cyc;
    Rxi = 1'b0;
    waitClocks(m);
    for (int i = 0; i < 8; i++) begin
      Rxi = d[i];
      waitClocks(m);
    end
    Rxi = p;
    waitClocks(m);
    Rxi = stop;
    waitClocks(m);
  endtask

  initial begin
    test_count  = 0;
    fail_count  = 0;
    cyc         = 0;
    pulse_count = 0;
    pulse_cyc   = 0;
    frame_start = 0;
    exp_pulses  = 0;
    rst_n = 1'b0;
    BC    = 3'b000;
    Rxi   = 1'b1;
    waitClocks(3);
    checkOutput("reset_data",   {24'd0, Rx_data}, 32'h0);
    checkOutput("reset_valid",  {31'd0, Rx_valid}, 32'h0);
    checkOutput("reset_perr",   {31'd0, Parity_err}, 32'h0);
    checkOutput("reset_ferr",   {31'd0, Frame_err}, 32'h0);
    checkOutput("reset_busy",   {31'd0, Rx_busy}, 32'h0);
    rst_n = 1'b1;
    waitClocks(5);

    $display("[TB] 1: BC=000 byte 0x0B");
    applyStimulus(8'h0B, 1'b1, 1'b1, 434);
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t1_pulses", pulse_count, exp_pulses);
    checkLatency("t1_latency", 434);
    checkOutput("t1_data", {24'd0, Rx_data}, 32'h0B);
    checkOutput("t1_perr", {31'd0, Parity_err}, 32'h0);
    checkOutput("t1_ferr", {31'd0, Frame_err}, 32'h0);
    checkOutput("t1_busy", {31'd0, Rx_busy}, 32'h0);

    $display("[TB] 2: BC=011 back-to-back 0xE8, 0x6F");
    BC = 3'b011;
    applyStimulus(8'hE8, 1'b0, 1'b1, 72);
    exp_pulses = exp_pulses + 1;
    checkOutput("t2_pulses_a", pulse_count, exp_pulses);
    checkOutput("t2_data_a", {24'd0, Rx_data}, 32'hE8);
    applyStimulus(8'h6F, 1'b0, 1'b1, 72);
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t2_pulses_b", pulse_count, exp_pulses);
    checkLatency("t2_latency_b", 72);
    checkOutput("t2_data_b", {24'd0, Rx_data}, 32'h6F);
    checkOutput("t2_perr", {31'd0, Parity_err}, 32'h0);
    checkOutput("t2_ferr", {31'd0, Frame_err}, 32'h0);

    $display("[TB] 3: BC=001 parity error then good frame");
    BC = 3'b001;
    applyStimulus(8'h0F, 1'b1, 1'b1, 217);
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t3_pulses", pulse_count, exp_pulses);
    checkOutput("t3_data", {24'd0, Rx_data}, 32'h0F);
    checkOutput("t3_perr", {31'd0, Parity_err}, 32'h1);
    checkOutput("t3_ferr", {31'd0, Frame_err}, 32'h0);
    applyStimulus(8'h0B, 1'b1, 1'b1, 217);
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t3_data_good", {24'd0, Rx_data}, 32'h0B);
    checkOutput("t3_perr_clear", {31'd0, Parity_err}, 32'h0);

    $display("[TB] 4: BC=100 stop bit low, line held low");
    BC = 3'b100;
    applyStimulus(8'h55, 1'b0, 1'b0, 36);
    exp_pulses = exp_pulses + 1;
    waitClocks(500);
    checkOutput("t4_pulses", pulse_count, exp_pulses);
    checkOutput("t4_data", {24'd0, Rx_data}, 32'h55);
    checkOutput("t4_ferr", {31'd0, Frame_err}, 32'h1);
    checkOutput("t4_perr", {31'd0, Parity_err}, 32'h0);
    checkOutput("t4_busy_low", {31'd0, Rx_busy}, 32'h1);
    Rxi = 1'b1;
    waitClocks(6);
    checkOutput("t4_busy_released", {31'd0, Rx_busy}, 32'h0);
    checkOutput("t4_no_extra_pulse", pulse_count, exp_pulses);

    $display("[TB] 5: start glitch then mid-frame BC change");
    BC = 3'b011;
    Rxi = 1'b0;
    waitClocks(5);
    checkOutput("t5_glitch_busy", {31'd0, Rx_busy}, 32'h1);
    waitClocks(27);
    Rxi = 1'b1;
    waitClocks(50);
    checkOutput("t5_glitch_busy_drop", {31'd0, Rx_busy}, 32'h0);
    checkOutput("t5_glitch_pulses", pulse_count, exp_pulses);
    checkOutput("t5_glitch_data", {24'd0, Rx_data}, 32'h55);
    checkOutput("t5_glitch_ferr", {31'd0, Frame_err}, 32'h1);
    fork
      applyStimulus(8'h96, 1'b0, 1'b1, 72);
      begin
        waitClocks(300);
        BC = 3'b000;
      end
    join
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t5_bc_pulses", pulse_count, exp_pulses);
    checkLatency("t5_bc_latency", 72);
    checkOutput("t5_bc_data", {24'd0, Rx_data}, 32'h96);
    checkOutput("t5_bc_ferr", {31'd0, Frame_err}, 32'h0);

    $display("[TB] 6: reset during data bit 4");
    BC = 3'b001;
    fork
      applyStimulus(8'hF1, 1'b1, 1'b1, 217);
      begin
        waitClocks(5 * 217 + 100);
        rst_n = 1'b0;
        waitClocks(1);
        rst_n = 1'b1;
        checkOutput("t6_rst_data", {24'd0, Rx_data}, 32'h0);
        checkOutput("t6_rst_busy", {31'd0, Rx_busy}, 32'h0);
        checkOutput("t6_rst_perr", {31'd0, Parity_err}, 32'h0);
      end
    join
    waitClocks(20);
    checkOutput("t6_no_pulse", pulse_count, exp_pulses);
    checkOutput("t6_busy_idle", {31'd0, Rx_busy}, 32'h0);
    applyStimulus(8'h3C, 1'b0, 1'b1, 217);
    exp_pulses = exp_pulses + 1;
    waitClocks(5);
    checkOutput("t6_pulses", pulse_count, exp_pulses);
    checkLatency("t6_latency", 217);
    checkOutput("t6_data", {24'd0, Rx_data}, 32'h3C);
    checkOutput("t6_perr", {31'd0, Parity_err}, 32'h0);
    checkOutput("t6_ferr", {31'd0, Frame_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
